// File: rtl/sgd_seq_pkg.sv
// Shared types and constants for the SGD training sequencer.
package sgd_seq_pkg;

  // Default datapath latency from the last osip input to a valid gradient at op_sgd.
  localparam int unsigned PIPE_LAT_DEF = 2;

  typedef enum logic [2:0] {
    StIdle,
    StDot,
    StDrain,
    StUpdate,
    StNext,
    StDone
  } seq_state_e;

  // Index width for a SIZE-entry vector; never narrower than one bit.
  function automatic int unsigned idx_w(int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/sgd_sequencer_if.sv
// Control/status bundle between the SGD sequencer and its host/datapath.
// Optional perf counters appear when SGD_SEQ_PERF_EN is defined.
interface sgd_sequencer_if
  import sgd_seq_pkg::*;
#(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned EPOCH_W  = 8
);

  localparam int unsigned IDX_W = idx_w(SIZE);

  logic                start;
  logic [SAMPLE_W-1:0] num_samples;
  logic [EPOCH_W-1:0]  num_epochs;
  logic                mem_ready;
  logic                busy;
  logic                done;
  logic [SAMPLE_W-1:0] sample_idx;
  logic [IDX_W-1:0]    elem_idx;
  logic                rd_en;
  logic                acc_clr;
  logic                grad_latch;
  logic                w_wr_en;
`ifdef SGD_SEQ_PERF_EN
  logic [31:0]         cycle_cnt;
  logic [31:0]         stall_cnt;

  modport master (
    output start, num_samples, num_epochs, mem_ready,
    input  busy, done, sample_idx, elem_idx, rd_en, acc_clr, grad_latch, w_wr_en,
    input  cycle_cnt, stall_cnt
  );

  modport slave (
    input  start, num_samples, num_epochs, mem_ready,
    output busy, done, sample_idx, elem_idx, rd_en, acc_clr, grad_latch, w_wr_en,
    output cycle_cnt, stall_cnt
  );
`else
  modport master (
    output start, num_samples, num_epochs, mem_ready,
    input  busy, done, sample_idx, elem_idx, rd_en, acc_clr, grad_latch, w_wr_en
  );

  modport slave (
    input  start, num_samples, num_epochs, mem_ready,
    output busy, done, sample_idx, elem_idx, rd_en, acc_clr, grad_latch, w_wr_en
  );
`endif

endinterface

// File: rtl/sgd_seq_cnt.sv
// Wrap counter: counts 0..max on en, wraps to 0 after max; clr has priority.
module sgd_seq_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;

  // Count register with synchronous clear and wrap at max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == max);

endmodule

// File: rtl/sgd_sequencer.sv
// SGD training-run sequencer: per sample streams SIZE dot-product reads, drains the
// datapath pipeline, then streams SIZE weight write-backs; repeats over samples/epochs.
// Define SGD_SEQ_PERF_EN to add the cycle_cnt/stall_cnt performance counters.
module sgd_sequencer
  import sgd_seq_pkg::*;
#(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned EPOCH_W  = 8
) (
  input logic             clk,
  input logic             rst,
  sgd_sequencer_if.slave  bus
);

  localparam int unsigned IDX_W = idx_w(SIZE);
  localparam int unsigned DRN_W = idx_w(PIPE_LAT);

  localparam logic [IDX_W-1:0] ElemMax  = IDX_W'(SIZE - 1);
  localparam logic [DRN_W-1:0] DrainMax = DRN_W'(PIPE_LAT - 1);

  seq_state_e state_q, state_d;

  logic [SAMPLE_W-1:0] num_samples_q;
  logic [EPOCH_W-1:0]  num_epochs_q;

  logic                accept;
  logic                busy;
  logic                rd_en;
  logic                wr_en;
  logic [IDX_W-1:0]    elem_cnt;
  logic                elem_last;
  logic [DRN_W-1:0]    drain_cnt;
  logic                drain_last;
  logic [SAMPLE_W-1:0] sample_cnt;
  logic                sample_last;
  logic [EPOCH_W-1:0]  epoch_cnt;
  logic                epoch_last;
  logic                unused_cnt;

  assign accept = (state_q == StIdle) && bus.start;
  assign busy   = (state_q != StIdle);
  // Strobes are decoded from registered state; mem_ready gates them in the same cycle so a
  // low ready stalls the stream without losing an element.
  assign rd_en  = (state_q == StDot) && bus.mem_ready;
  assign wr_en  = (state_q == StUpdate) && bus.mem_ready;

  // Element index shared by the read and write-back streams.
  sgd_seq_cnt #(.W(IDX_W)) u_elem_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (rd_en | wr_en),
    .clr  (accept),
    .max  (ElemMax),
    .cnt  (elem_cnt),
    .last (elem_last)
  );

  sgd_seq_cnt #(.W(DRN_W)) u_drain_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == StDrain),
    .clr  (accept),
    .max  (DrainMax),
    .cnt  (drain_cnt),
    .last (drain_last)
  );

  sgd_seq_cnt #(.W(SAMPLE_W)) u_sample_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == StNext),
    .clr  (accept),
    .max  (num_samples_q - SAMPLE_W'(1)),
    .cnt  (sample_cnt),
    .last (sample_last)
  );

  sgd_seq_cnt #(.W(EPOCH_W)) u_epoch_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   ((state_q == StNext) && sample_last),
    .clr  (accept),
    .max  (num_epochs_q - EPOCH_W'(1)),
    .cnt  (epoch_cnt),
    .last (epoch_last)
  );

  // Only the wrap flags of the drain and epoch counters are needed.
  assign unused_cnt = ^{drain_cnt, epoch_cnt};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Run parameters are captured once; later changes on the inputs are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_samples_q <= '0;
      num_epochs_q  <= '0;
    end else if (accept) begin
      num_samples_q <= bus.num_samples;
      num_epochs_q  <= bus.num_epochs;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if ((bus.num_samples == '0) || (bus.num_epochs == '0)) begin
            state_d = StDone;
          end else begin
            state_d = StDot;
          end
        end
      end
      StDot:    if (rd_en && elem_last) state_d = StDrain;
      StDrain:  if (drain_last) state_d = StUpdate;
      StUpdate: if (wr_en && elem_last) state_d = StNext;
      StNext:   state_d = (sample_last && epoch_last) ? StDone : StDot;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign bus.busy       = busy;
  assign bus.done       = (state_q == StDone);
  assign bus.sample_idx = sample_cnt;
  assign bus.elem_idx   = elem_cnt;
  assign bus.rd_en      = rd_en;
  assign bus.acc_clr    = rd_en && (elem_cnt == '0);
  assign bus.grad_latch = (state_q == StDrain) && drain_last;
  assign bus.w_wr_en    = wr_en;

`ifdef SGD_SEQ_PERF_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        stalled;

  assign stalled = ((state_q == StDot) || (state_q == StUpdate)) && !bus.mem_ready;

  // Saturating busy-cycle and stall-cycle counters, cleared when a run is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (accept) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (busy && (cycle_cnt_q != '1)) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (stalled && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sgd_sequencer.sv
// Scoreboard bench for sgd_sequencer (SIZE=4, PIPE_LAT=2).
module tb_sgd_sequencer;

  localparam int unsigned SIZE     = 4;
  localparam int unsigned PIPE_LAT = 2;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned EPOCH_W  = 8;

  // Event flag bits: {done, w_wr_en, grad_latch, acc_clr, rd_en}
  typedef struct {
    int unsigned t;
    logic [4:0]  flags;
    int unsigned elem;
    int unsigned sample;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned t0  = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned stall_from = 0;
  int unsigned stall_len  = 0;
  int unsigned ev_limit   = 32'hffff_ffff;
  ev_t         exp_q[$];

  sgd_sequencer_if #(.SIZE(SIZE), .SAMPLE_W(SAMPLE_W), .EPOCH_W(EPOCH_W)) bus ();

  sgd_sequencer #(
    .SIZE     (SIZE),
    .PIPE_LAT (PIPE_LAT),
    .SAMPLE_W (SAMPLE_W),
    .EPOCH_W  (EPOCH_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (rel cycle %0d)", name, got, want, cyc - t0);
    end
  endfunction

  function automatic logic rdy(int unsigned t);
    return !(stall_len != 0 && t >= stall_from && t < stall_from + stall_len);
  endfunction

  function automatic void push(int unsigned t, logic [4:0] f, int unsigned e, int unsigned s);
    ev_t ev;
    if (t >= ev_limit) return;
    ev.t = t; ev.flags = f; ev.elem = e; ev.sample = s;
    exp_q.push_back(ev);
  endfunction

  // Cycle-by-cycle timing model of a run; returns the cycle of the done pulse.
  function automatic int unsigned build(int unsigned ns, int unsigned ne);
    int unsigned t = 1;
    int unsigned e_i;
    if (ns == 0 || ne == 0) begin
      push(t, 5'b10000, 0, 0);
      return t;
    end
    for (int unsigned ep = 0; ep < ne; ep++) begin
      for (int unsigned s = 0; s < ns; s++) begin
        e_i = 0;
        while (e_i < SIZE) begin
          if (rdy(t)) begin
            push(t, {3'b000, e_i == 0, 1'b1}, e_i, s);
            e_i++;
          end
          t++;
        end
        for (int unsigned d = 0; d < PIPE_LAT; d++) begin
          if (d == PIPE_LAT - 1) push(t, 5'b00100, 0, s);
          t++;
        end
        e_i = 0;
        while (e_i < SIZE) begin
          if (rdy(t)) begin
            push(t, 5'b01000, e_i, s);
            e_i++;
          end
          t++;
        end
        t++;
      end
    end
    push(t, 5'b10000, 0, 0);
    return t;
  endfunction

  // Monitor: every cycle with a strobe or done must match the head of the queue.
  always @(negedge clk) begin
    logic [4:0] f;
    ev_t        ev;
    if (!rst) begin
      f = {bus.done, bus.w_wr_en, bus.grad_latch, bus.acc_clr, bus.rd_en};
      if (f != 5'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_event: got flags %b, want none (rel cycle %0d)", f, cyc - t0);
        end else begin
          ev = exp_q.pop_front();
          check("ev_cycle", 64'(cyc - t0), 64'(ev.t));
          check("ev_flags", 64'(f), 64'(ev.flags));
          check("ev_elem", 64'(bus.elem_idx), 64'(ev.elem));
          check("ev_sample", 64'(bus.sample_idx), 64'(ev.sample));
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(string tag, int unsigned ns, int unsigned ne, int unsigned sf,
                          int unsigned sl, int unsigned start_again, int unsigned exp_done);
    int unsigned d;
    stall_from = sf;
    stall_len  = sl;
    ev_limit   = 32'hffff_ffff;
    t0 = cyc;
    d = build(ns, ne);
    bus.num_samples = SAMPLE_W'(ns);
    bus.num_epochs  = EPOCH_W'(ne);
    bus.mem_ready   = 1'b1;
    bus.start       = 1'b1;
    for (int unsigned r = 1; r <= exp_done + 1; r++) begin
      next_cycle();
      bus.start       = (r == start_again);
      bus.num_samples = '0;
      bus.num_epochs  = '0;
      bus.mem_ready   = rdy(r);
      #1;
      if (sl != 0 && r >= sf && r < sf + sl) begin
        check({tag, "_stall_rd_en"}, 64'(bus.rd_en), 64'd0);
        check({tag, "_stall_elem_hold"}, 64'(bus.elem_idx), 64'd2);
      end
      if (r == exp_done) check({tag, "_done"}, 64'(bus.done), 64'd1);
      if (r == exp_done + 1) check({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
    end
    bus.mem_ready = 1'b1;
    stall_len     = 0;
    check({tag, "_events_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
`ifdef SGD_SEQ_PERF_EN
    check({tag, "_cycle_cnt"}, 64'(bus.cycle_cnt), 64'(exp_done));
    check({tag, "_stall_cnt"}, 64'(bus.stall_cnt), 64'(sl));
`endif
    if (d == 0) $display("note: empty model for %s", tag);
  endtask

  initial begin
    int unsigned d;
    bus.start       = 1'b0;
    bus.mem_ready   = 1'b1;
    bus.num_samples = '0;
    bus.num_epochs  = '0;
    rst = 1'b1;
    repeat (3) next_cycle();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_strobes", 64'({bus.rd_en, bus.acc_clr, bus.grad_latch, bus.w_wr_en}), 64'd0);
    check("rst_elem_idx", 64'(bus.elem_idx), 64'd0);
    check("rst_sample_idx", 64'(bus.sample_idx), 64'd0);
    rst = 1'b0;
    next_cycle();

    run_case("single", 1, 1, 0, 0, 0, 12);
    run_case("three_by_two", 3, 2, 0, 0, 0, 67);
    run_case("stall", 1, 1, 3, 3, 0, 15);
    run_case("zero_epochs", 1, 0, 0, 0, 0, 1);
    run_case("start_ignored", 1, 1, 0, 0, 5, 12);

    // Abort in UPDATE at cycle 8: events only up to cycle 7 are expected, never done.
    stall_len = 0;
    ev_limit  = 8;
    t0 = cyc;
    d = build(1, 1);
    bus.num_samples = SAMPLE_W'(1);
    bus.num_epochs  = EPOCH_W'(1);
    bus.start       = 1'b1;
    for (int unsigned r = 1; r <= 8; r++) begin
      next_cycle();
      bus.start = 1'b0;
    end
    check("abort_pre_wr_en", 64'(bus.w_wr_en), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_strobes", 64'({bus.rd_en, bus.acc_clr, bus.grad_latch, bus.w_wr_en}), 64'd0);
    check("abort_elem_idx", 64'(bus.elem_idx), 64'd0);
    check("abort_events_left", 64'(exp_q.size()), 64'd0);
`ifdef SGD_SEQ_PERF_EN
    check("abort_cycle_cnt", 64'(bus.cycle_cnt), 64'd0);
`endif
    exp_q.delete();
    repeat (2) next_cycle();
    rst = 1'b0;
    repeat (6) next_cycle();
    check("abort_idle_busy", 64'(bus.busy), 64'd0);
    if (d == 0) $display("note: empty abort model");

    run_case("after_reset", 1, 1, 0, 0, 0, 12);

    repeat (2) next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
